trap_redirect_unit: RTL and testbench
=====================================

Name: trap_redirect_unit

Overview:
- Sequential exception/redirect controller directly upstream of the PC select mux.
- Drives the 2-bit PC-mux select, the exception target address and the PC write enable.
- Normally passes the control unit's sequential/branch choice through unchanged.
- On an illegal-opcode or arithmetic-overflow event it saves EPC and cause, fetches the handler address from a fixed vector location in memory, then redirects the PC once.

Parameters:
- VEC_ILLEGAL, 64'd254, memory address holding the illegal-opcode handler address
- VEC_OVERFLOW, 64'd255, memory address holding the overflow handler address
- PC_OFFSET, 64'd4, subtracted from pc_current to form EPC
- CAUSE_ILLEGAL, 64'd0, cause code for illegal opcode
- CAUSE_OVERFLOW, 64'd1, cause code for overflow

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_current  in  64  current PC register value
- pc_src_branch  in  1  control unit: 0 = sequential PC, 1 = branch/jump target
- pc_write_req  in  1  control unit PC write request
- exc_illegal  in  1  illegal opcode detected, level, sampled on clk
- exc_overflow  in  1  ALU overflow detected, level, sampled on clk
- mem_req  out  1  vector read request
- mem_addr  out  64  vector read address
- mem_rdata  in  64  vector read data
- mem_ack  in  1  read data valid this cycle
- mux_pc_signal  out  2  PC-mux select: 0 = sequential, 1 = branch, 2 = exception
- pc_exception  out  64  handler address to the PC mux
- pc_write  out  1  PC register write enable
- epc_out  out  64  saved exception PC
- cause_out  out  64  saved cause code
- busy  out  1  high whenever state != IDLE; the control unit stalls on it

Behaviour:
- Reset is synchronous and active-high: on a clk edge with reset=1, state=IDLE, and epc_out, cause_out, pc_exception and the pending-cause register all become 0.
- Reset has priority over every other event, including mid-trap in any state. mem_req deasserts in the cycle after that edge.
- States: IDLE, SAVE, REQ, REDIRECT. Outputs are Moore-decoded from the state, except the IDLE pass-through.
- IDLE:
  - mux_pc_signal = {1'b0, pc_src_branch}; pc_write = pc_write_req; mem_req = 0; busy = 0.
  - If exc_illegal or exc_overflow is high at the edge: latch the pending cause and go to SAVE.
  - Priority: illegal over overflow when both are high.
  - pc_write_req is ignored in the exception cycle; pc_write is forced to 0 whenever either exc input is high in IDLE.
- SAVE (1 cycle):
  - pc_write = 0, mux_pc_signal = 0, busy = 1.
  - At the edge: epc_out <= pc_current - PC_OFFSET (64-bit, wraps modulo 2^64); cause_out <= pending cause code; next state REQ.
- REQ:
  - mem_req = 1; mem_addr = VEC_ILLEGAL or VEC_OVERFLOW per the pending cause; pc_write = 0.
  - Remains in REQ while mem_ack = 0, with no timeout.
  - On an edge with mem_ack = 1: pc_exception <= mem_rdata; go to REDIRECT. mem_ack may already be high in the first REQ cycle.
  - mem_ack outside REQ is ignored.
- REDIRECT (1 cycle):
  - mux_pc_signal = 2; pc_write = 1; busy = 1; then IDLE.
- mem_addr = 0 whenever not in REQ.
- Exception inputs are ignored outside IDLE; no nesting or queuing. A level still high on return to IDLE starts a new trap.
- Minimum latency with zero-wait ack: exception sampled at edge 0, then SAVE, REQ, and REDIRECT in cycles 1, 2, 3. The new PC is loaded at the end of cycle 3.
- The block never drives mux_pc_signal = 3.

Test Plan:
- Reset: assert reset 2 cycles during REQ (mem_req=1) -> next cycle state IDLE, mem_req=0, epc_out=0, cause_out=0, pc_exception=0, busy=0.
- Pass-through: in IDLE with no exceptions, toggle pc_src_branch 0/1 with pc_write_req=1 -> mux_pc_signal 0/1 in the same cycle, pc_write=1, mem_req never asserted.
- Illegal opcode, zero-wait: pc_current=0x108, pulse exc_illegal, ack in the first REQ cycle with mem_rdata=0x400 -> mem_addr=254 in REQ, epc_out=0x104, cause_out=0, REDIRECT in cycle 3 with mux_pc_signal=2, pc_exception=0x400, pc_write=1.
- Overflow with 3 wait cycles, exc_illegal held 0 throughout: pc_current=0x20, exc_overflow=1, mem_ack delayed 3 cycles, mem_rdata=0x800 -> mem_req high for 4 cycles at mem_addr=255, cause_out=1, epc_out=0x1C, REDIRECT in cycle 6.
- Simultaneous exceptions: exc_illegal=exc_overflow=1 in the same cycle -> cause_out=0, mem_addr=254; an exc_overflow pulse during REQ is ignored and does not start a second trap.
- Wrap-around: pc_current=0x0, exc_illegal -> epc_out=0xFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/trap_redirect_unit.sv
// Exception/redirect controller feeding the PC-select mux: saves EPC/cause, fetches handler vector, redirects PC once.
// Latency: exception at edge 0 -> SAVE, REQ, REDIRECT in cycles 1..3 with zero-wait ack; REQ extends per wait cycle.
// Backpressure: busy stalls the control unit for the whole trap; REQ holds mem_req until mem_ack, no timeout.
module trap_redirect_unit #(
  parameter logic [63:0] VEC_ILLEGAL    = 64'd254,
  parameter logic [63:0] VEC_OVERFLOW   = 64'd255,
  parameter logic [63:0] PC_OFFSET      = 64'd4,
  parameter logic [63:0] CAUSE_ILLEGAL  = 64'd0,
  parameter logic [63:0] CAUSE_OVERFLOW = 64'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_current,
  input  logic        pc_src_branch,
  input  logic        pc_write_req,
  input  logic        exc_illegal,
  input  logic        exc_overflow,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  mux_pc_signal,
  output logic [63:0] pc_exception,
  output logic        pc_write,
  output logic [63:0] epc_out,
  output logic [63:0] cause_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SAVE, REQ, REDIRECT} state_t;

  state_t state;
  logic   pend_ovf;
  logic   exc_any;

  assign exc_any = exc_illegal | exc_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pend_ovf     <= 1'b0;
      epc_out      <= '0;
      cause_out    <= '0;
      pc_exception <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_any) begin
            // illegal wins when both fire together
            pend_ovf <= ~exc_illegal;
            state    <= SAVE;
          end
        end
        SAVE: begin
          epc_out   <= pc_current - PC_OFFSET;
          cause_out <= pend_ovf ? CAUSE_OVERFLOW : CAUSE_ILLEGAL;
          state     <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            pc_exception <= mem_rdata;
            state        <= REDIRECT;
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mux_pc_signal = 2'd0;
    pc_write      = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        mux_pc_signal = {1'b0, pc_src_branch};
        // the control unit's write request is dropped in the cycle an exception is raised
        pc_write      = pc_write_req & ~exc_any;
        busy          = 1'b0;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = pend_ovf ? VEC_OVERFLOW : VEC_ILLEGAL;
      end
      REDIRECT: begin
        mux_pc_signal = 2'd2;
        pc_write      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_redirect_unit.sv
// Bench for trap_redirect_unit: cycle-timeline model checked every cycle, plus directed literal checks.
module tb_trap_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_current;
  logic        pc_src_branch;
  logic        pc_write_req;
  logic        exc_illegal;
  logic        exc_overflow;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  mux_pc_signal;
  logic [63:0] pc_exception;
  logic        pc_write;
  logic [63:0] epc_out;
  logic [63:0] cause_out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  trap_redirect_unit dut (
    .clk(clk), .reset(reset), .pc_current(pc_current),
    .pc_src_branch(pc_src_branch), .pc_write_req(pc_write_req),
    .exc_illegal(exc_illegal), .exc_overflow(exc_overflow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mux_pc_signal(mux_pc_signal),
    .pc_exception(pc_exception), .pc_write(pc_write),
    .epc_out(epc_out), .cause_out(cause_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts cycles spent in the current trap (0 = none), ack_at is the trap cycle
  // in which the vector read completed (-1 until then).
  int          t = 0;
  int          ack_at = -1;
  bit          m_ovf = 1'b0;
  bit          chk_en = 1'b0;
  logic [63:0] m_epc = '0, m_cause = '0, m_pcx = '0;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; ack_at = -1; m_ovf = 1'b0;
      m_epc = '0; m_cause = '0; m_pcx = '0;
      chk_en = 1'b1;
    end else if (t == 0) begin
      if (exc_illegal || exc_overflow) begin
        t = 1; ack_at = -1; m_ovf = !exc_illegal;
      end
    end else if (t == 1) begin
      m_epc   = pc_current - 64'd4;
      m_cause = m_ovf ? 64'd1 : 64'd0;
      t = 2;
    end else if (ack_at < 0) begin
      if (mem_ack) begin
        ack_at = t;
        m_pcx  = mem_rdata;
      end
      t = t + 1;
    end else begin
      t = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0]  e_mux;
      logic        e_pcw, e_req, e_busy;
      logic [63:0] e_addr;
      e_mux = 2'd0; e_pcw = 1'b0; e_req = 1'b0; e_busy = 1'b1; e_addr = '0;
      if (t == 0) begin
        e_mux  = {1'b0, pc_src_branch};
        e_pcw  = pc_write_req && !(exc_illegal || exc_overflow);
        e_busy = 1'b0;
      end else if (t >= 2 && ack_at < 0) begin
        e_req  = 1'b1;
        e_addr = m_ovf ? 64'd255 : 64'd254;
      end else if (t >= 2) begin
        e_mux = 2'd2;
        e_pcw = 1'b1;
      end
      chk("mux_pc_signal", {62'd0, mux_pc_signal}, {62'd0, e_mux});
      chk("pc_write", {63'd0, pc_write}, {63'd0, e_pcw});
      chk("mem_req", {63'd0, mem_req}, {63'd0, e_req});
      chk("mem_addr", mem_addr, e_addr);
      chk("busy", {63'd0, busy}, {63'd0, e_busy});
      chk("epc_out", epc_out, m_epc);
      chk("cause_out", cause_out, m_cause);
      chk("pc_exception", pc_exception, m_pcx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    int nreq;
    reset = 1'b1; pc_current = '0; pc_src_branch = 1'b0; pc_write_req = 1'b0;
    exc_illegal = 1'b0; exc_overflow = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    look();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_epc", epc_out, 64'd0);

    // pass-through
    pc_write_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_src_branch = i[0];
      look();
      chk("pass_mux", {62'd0, mux_pc_signal}, {63'd0, i[0]});
      chk("pass_pcw", {63'd0, pc_write}, 64'd1);
      chk("pass_req", {63'd0, mem_req}, 64'd0);
      tick();
    end
    pc_src_branch = 1'b0;

    // illegal opcode, zero-wait ack (ack held early to show it is ignored outside REQ)
    pc_current = 64'h108; exc_illegal = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h400;
    look();
    chk("exc_cycle_pcw", {63'd0, pc_write}, 64'd0);
    tick();                                   // cycle 1: SAVE
    exc_illegal = 1'b0;
    look();
    chk("ill_save_busy", {63'd0, busy}, 64'd1);
    chk("ill_save_req", {63'd0, mem_req}, 64'd0);
    tick();                                   // cycle 2: REQ
    chk("ill_req", {63'd0, mem_req}, 64'd1);
    chk("ill_addr", mem_addr, 64'd254);
    chk("ill_epc", epc_out, 64'h104);
    chk("ill_cause", cause_out, 64'd0);
    tick();                                   // cycle 3: REDIRECT
    mem_ack = 1'b0;
    chk("ill_mux", {62'd0, mux_pc_signal}, 64'd2);
    chk("ill_pcx", pc_exception, 64'h400);
    chk("ill_pcw", {63'd0, pc_write}, 64'd1);
    tick();
    chk("ill_done", {63'd0, busy}, 64'd0);

    // overflow, 3 wait cycles
    pc_write_req = 1'b0;
    pc_current = 64'h20; exc_overflow = 1'b1; mem_rdata = 64'h800;
    tick();
    exc_overflow = 1'b0;
    nreq = 0;
    for (int c = 1; c <= 5; c++) begin
      mem_ack = (c == 5);
      look();
      if (mem_req) begin
        nreq++;
        chk("ovf_addr", mem_addr, 64'd255);
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("ovf_req_cycles", 64'(nreq), 64'd4);
    chk("ovf_redirect_c6", {62'd0, mux_pc_signal}, 64'd2);
    chk("ovf_cause", cause_out, 64'd1);
    chk("ovf_epc", epc_out, 64'h1C);
    chk("ovf_pcx", pc_exception, 64'h800);
    tick();

    // simultaneous exceptions, overflow pulse during REQ ignored
    pc_current = 64'h300; exc_illegal = 1'b1; exc_overflow = 1'b1;
    tick();
    exc_illegal = 1'b0; exc_overflow = 1'b0;
    tick();
    chk("sim_addr", mem_addr, 64'd254);
    chk("sim_cause", cause_out, 64'd0);
    exc_overflow = 1'b1;
    tick();
    exc_overflow = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("sim_no_retrap", {63'd0, busy}, 64'd0);

    // wrap-around EPC, then reset in the middle of REQ
    pc_current = 64'h0; exc_illegal = 1'b1;
    tick();
    exc_illegal = 1'b0;
    tick();
    chk("wrap_epc", epc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    tick();
    chk("rst_req_drop", {63'd0, mem_req}, 64'd0);
    tick();
    reset = 1'b0;
    look();
    chk("rst2_busy", {63'd0, busy}, 64'd0);
    chk("rst2_epc", epc_out, 64'd0);
    chk("rst2_cause", cause_out, 64'd0);
    chk("rst2_pcx", pc_exception, 64'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
